// File: rtl/latch_delay_bank_if.sv
// Control/data bundle for latch_delay_bank: strobes and pulse inputs in, delayed pulses and drop counters out.
interface latch_delay_bank_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned TAP_W    = 2,
    parameter int unsigned CNT_W    = 4
);
    logic                      ce;
    logic                      sync_reset;
    logic                      enable;
    logic                      clear_drops;
    logic [CHANNELS-1:0]       data_in;
    logic [CHANNELS*TAP_W-1:0] tap_sel;
    logic [CHANNELS-1:0]       data_out;
    logic [CHANNELS*CNT_W-1:0] drop_count;

    modport master (
        output ce, sync_reset, enable, clear_drops, data_in, tap_sel,
        input  data_out, drop_count
    );

    modport slave (
        input  ce, sync_reset, enable, clear_drops, data_in, tap_sel,
        output data_out, drop_count
    );
endinterface

// File: rtl/latch_delay_bank.sv
// Multi-channel strobed pulse delay line: pulses latch until the shared enable strobe, then shift
// through a DEPTH-stage line with a run-time selectable output tap and a saturating merge counter.
module latch_delay_bank #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CNT_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    latch_delay_bank_if.slave  bus
);
    localparam int unsigned TAP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [TAP_W:0] TAP_MAX = (TAP_W + 1)'(DEPTH - 1);

    logic [CHANNELS-1:0] pend;
    logic [DEPTH-1:0]    line    [CHANNELS];
    logic [DEPTH-1:0]    shifted [CHANNELS];
    logic [CNT_W-1:0]    drop    [CHANNELS];
    logic [TAP_W:0]      tap_eff [CHANNELS];
    logic [CHANNELS-1:0] tapped;

    // Next line contents on a strobe: newest sample (pending latch or fresh pulse) enters stage 0.
    always_comb begin
        for (int c = 0; c < int'(CHANNELS); c++) begin
            shifted[c]    = line[c] << 1;
            shifted[c][0] = bus.data_in[c] | pend[c];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= '0;
            for (int c = 0; c < int'(CHANNELS); c++) begin
                line[c] <= '0;
                drop[c] <= '0;
            end
        end else if (bus.ce) begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                if (bus.sync_reset) begin
                    pend[c] <= 1'b0;
                    line[c] <= '0;
                end else if (bus.enable) begin
                    line[c] <= shifted[c];
                    pend[c] <= 1'b0;
                end else begin
                    pend[c] <= pend[c] | bus.data_in[c];
                end

                // A pulse arriving on top of a pending one merges; count it unless cleared this cycle.
                if (bus.clear_drops) begin
                    drop[c] <= '0;
                end else if (!bus.sync_reset && bus.data_in[c] && pend[c] && (drop[c] != '1)) begin
                    drop[c] <= drop[c] + CNT_W'(1);
                end
            end
        end
    end

    // Tap select is live (not ce-gated) and clamps out-of-range values to the last stage.
    always_comb begin
        tapped = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            tap_eff[c] = {1'b0, bus.tap_sel[c*TAP_W +: TAP_W]};
            if (tap_eff[c] > TAP_MAX) begin
                tap_eff[c] = TAP_MAX;
            end
            for (int s = 0; s < int'(DEPTH); s++) begin
                if (tap_eff[c] == (TAP_W + 1)'(s)) begin
                    tapped[c] = line[c][s];
                end
            end
        end
    end

    assign bus.data_out = tapped & {CHANNELS{bus.enable}};

    always_comb begin
        bus.drop_count = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            bus.drop_count[c*CNT_W +: CNT_W] = drop[c];
        end
    end
endmodule
